// File: rtl/pipe_pkg.sv
// Shared widths for the inter-stage pipeline registers and their performance counters.
package pipe_pkg;

  localparam int IFID_CLR_W   = 38;
  localparam int IFID_KEEP_W  = 37;
  localparam int IDEX_CLR_W   = 38;
  localparam int IDEX_KEEP_W  = 37;
  localparam int EXMEM_CLR_W  = 38;
  localparam int EXMEM_KEEP_W = 37;
  localparam int MEMWB_CLR_W  = 38;
  localparam int MEMWB_KEEP_W = 37;

  localparam int STALL_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear, shared by the perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flushable and sticky payload groups.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CLR_W  = MEMWB_CLR_W,
  parameter int KEEP_W = MEMWB_KEEP_W,
  parameter int CNT_W  = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CLR_W-1:0]  in_clr,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLR_W-1:0]  out_clr,
  output logic [KEEP_W-1:0] out_keep,
  input  logic              stall_cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic [CLR_W-1:0]  main_clr;
  logic [KEEP_W-1:0] main_keep;
  logic              accept;
  logic              drain;

  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_clr   = main_clr;
  assign out_keep  = main_keep;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CLR_W-1:0]  skid_clr;
  logic [KEEP_W-1:0] skid_keep;

  // Taken straight from a flop so upstream sees no combinational path from out_ready.
  assign in_ready = ~skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_clr   <= '0;
      main_keep  <= '0;
      skid_valid <= 1'b0;
      skid_clr   <= '0;
      skid_keep  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_clr   <= '0;
      skid_valid <= 1'b0;
      skid_clr   <= '0;
      if (accept)          main_keep <= in_keep;
      else if (skid_valid) main_keep <= skid_keep;
    end else if (drain && skid_valid) begin
      main_clr   <= skid_clr;
      main_keep  <= skid_keep;
      skid_valid <= accept;
      if (accept) begin
        skid_clr  <= in_clr;
        skid_keep <= in_keep;
      end
    end else if (accept && main_valid && !drain) begin
      skid_valid <= 1'b1;
      skid_clr   <= in_clr;
      skid_keep  <= in_keep;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_clr   <= in_clr;
      main_keep  <= in_keep;
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end
`else
  // Single entry: a draining slot can be refilled in the same cycle.
  assign in_ready = out_ready | ~main_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_clr   <= '0;
      main_keep  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_clr   <= '0;
      if (accept) main_keep <= in_keep;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_clr   <= in_clr;
      main_keep  <= in_keep;
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end
`endif

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_valid & ~out_ready),
    .clr   (stall_cnt_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg (default 16-bit and 3-bit stall counter).
module tb_pipe_stage_reg;

  localparam int CLR_W  = 38;
  localparam int KEEP_W = 37;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CLR_W-1:0]  in_clr;
  logic [KEEP_W-1:0] in_keep;
  logic              flush;
  logic              out_ready;
  logic              stall_cnt_clr;

  logic              in_ready,  in_ready_s;
  logic              out_valid, out_valid_s;
  logic [CLR_W-1:0]  out_clr,   out_clr_s;
  logic [KEEP_W-1:0] out_keep,  out_keep_s;
  logic [15:0]       stall_cnt;
  logic [2:0]        stall_cnt_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_clr(in_clr), .in_keep(in_keep), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_clr(out_clr), .out_keep(out_keep),
    .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_clr(in_clr), .in_keep(in_keep), .flush(flush),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_clr(out_clr_s), .out_keep(out_keep_s),
    .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt_s)
  );

  typedef struct {
    logic              in_valid;
    logic [CLR_W-1:0]  in_clr;
    logic [KEEP_W-1:0] in_keep;
    logic              flush;
    logic              out_ready;
    logic              exp_in_ready;
    logic              exp_valid;
    logic [CLR_W-1:0]  exp_clr;
    logic [KEEP_W-1:0] exp_keep;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Streaming, flush with and without accept, then a fresh beat left held.
    vecs[0] = '{1'b1, 38'h1,  37'h101,  1'b0, 1'b1, 1'b1, 1'b1, 38'h1, 37'h101};
    vecs[1] = '{1'b1, 38'h2,  37'h102,  1'b0, 1'b1, 1'b1, 1'b1, 38'h2, 37'h102};
    vecs[2] = '{1'b1, 38'h3,  37'h103,  1'b0, 1'b1, 1'b1, 1'b1, 38'h3, 37'h103};
    vecs[3] = '{1'b1, 38'h4,  37'h104,  1'b0, 1'b1, 1'b1, 1'b1, 38'h4, 37'h104};
    vecs[4] = '{1'b0, 38'h0,  37'h0,    1'b0, 1'b1, 1'b1, 1'b0, 38'h4, 37'h104};
    vecs[5] = '{1'b1, 38'hAB, 37'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 38'h0, 37'h1234};
    vecs[6] = '{1'b0, 38'hCD, 37'h777,  1'b1, 1'b1, 1'b1, 1'b0, 38'h0, 37'h1234};
    vecs[7] = '{1'b1, 38'h55, 37'h9,    1'b0, 1'b0, 1'b1, 1'b1, 38'h55, 37'h9};

    rst = 1'b1; in_valid = 1'b1; in_clr = 38'h15; in_keep = 37'h77;
    flush = 1'b0; out_ready = 1'b0; stall_cnt_clr = 1'b0;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_clr",   64'(out_clr),   64'd0);
    check("rst_out_keep",  64'(out_keep),  64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

    rst = 1'b0; in_clr = 38'h21; in_keep = 37'h5;
    #1 check("first_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_out_clr",   64'(out_clr),   64'h21);

    for (int i = 0; i < 8; i++) begin
      in_valid  = vecs[i].in_valid;
      in_clr    = vecs[i].in_clr;
      in_keep   = vecs[i].in_keep;
      flush     = vecs[i].flush;
      out_ready = vecs[i].out_ready;
      #1 check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_out_clr", i),   64'(out_clr),   64'(vecs[i].exp_clr));
      check($sformatf("vec%0d_out_keep", i),  64'(out_keep),  64'(vecs[i].exp_keep));
    end
    check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    // Five stall cycles with beat 0x55 held.
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifndef PIPE_STAGE_SKID_EN
      check($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
`endif
      tick();
      check($sformatf("hold%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_out_clr", i),   64'(out_clr),   64'h55);
      check($sformatf("hold%0d_out_keep", i),  64'(out_keep),  64'h9);
    end
    check("stall_cnt_5",     64'(stall_cnt),   64'd5);
    check("stall_cnt_sat_5", 64'(stall_cnt_s), 64'd5);

    stall_cnt_clr = 1'b1;
    tick();
    check("stall_cnt_clr",     64'(stall_cnt),   64'd0);
    check("stall_cnt_sat_clr", 64'(stall_cnt_s), 64'd0);
    stall_cnt_clr = 1'b0;

    for (int i = 0; i < 10; i++) tick();
    check("stall_cnt_10",      64'(stall_cnt),   64'd10);
    check("stall_cnt_sat_top", 64'(stall_cnt_s), 64'd7);

    // Flush while held: beat dies, sticky keep survives, counter still counts that edge.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("hold_flush_valid", 64'(out_valid), 64'd0);
    check("hold_flush_clr",   64'(out_clr),   64'd0);
    check("hold_flush_keep",  64'(out_keep),  64'h9);
    tick();
    check("stall_cnt_after_flush", 64'(stall_cnt), 64'd11);

`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b1; in_clr = 38'hA1; in_keep = 37'h1;
    #1 check("skid_a_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_clr = 38'hB2; in_keep = 37'h2;
    check("skid_b_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("skid_full_in_ready", 64'(in_ready), 64'd0);
    check("skid_full_out_clr",  64'(out_clr),  64'hA1);
    out_ready = 1'b1;
    tick();
    check("skid_drain_b_valid", 64'(out_valid), 64'd1);
    check("skid_drain_b_clr",   64'(out_clr),   64'hB2);
    check("skid_drain_b_keep",  64'(out_keep),  64'h2);
    check("skid_reopen",        64'(in_ready),  64'd1);
    tick();
    check("skid_empty_valid", 64'(out_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
